// File: rtl/loadstore_mem_responder.sv
// loadstore_mem_responder: in-order load/store queue to a fixed-latency SRAM with a credit-guarded load-response FIFO
module loadstore_mem_responder #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 32,
  parameter int TAG_W       = 4,
  parameter int REQ_DEPTH   = 4,
  parameter int MEM_LATENCY = 2,
  parameter int RSP_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              ls__mc__valid,
  output logic              mc__ls__ready,
  input  logic [1:0]        ls__mc__cntl,
  input  logic [TAG_W-1:0]  ls__mc__tag,
  input  logic [ADDR_W-1:0] ls__mc__addr,
  input  logic [DATA_W-1:0] ls__mc__data,
  output logic              mc__ls__rsp_valid,
  input  logic              ls__mc__rsp_ready,
  output logic [TAG_W-1:0]  mc__ls__rsp_tag,
  output logic [DATA_W-1:0] mc__ls__rsp_data,
  output logic              mc__ls__err,
  output logic              mc__mem__enable,
  output logic              mc__mem__wr,
  output logic [ADDR_W-1:0] mc__mem__addr,
  output logic [DATA_W-1:0] mc__mem__wdata,
  input  logic [DATA_W-1:0] mem__mc__rdata
);
  localparam int QW = $clog2(REQ_DEPTH);
  localparam int QC = $clog2(REQ_DEPTH + 1);
  localparam int RW = $clog2(RSP_DEPTH);
  localparam int RC = $clog2(RSP_DEPTH + 1);
  localparam int EW = 1 + TAG_W + ADDR_W + DATA_W;
  logic [EW-1:0]           req_mem [REQ_DEPTH];
  logic [QW-1:0]           req_wp, req_rp;
  logic [QC-1:0]           req_cnt, req_cnt_n;
  logic [TAG_W+DATA_W-1:0] rsp_mem [RSP_DEPTH];
  logic [RW-1:0]           rsp_wp, rsp_rp;
  logic [RC-1:0]           rsp_cnt, out_cnt;
  logic [RC:0]             credit;
  logic [MEM_LATENCY-1:0]  rv;
  logic [TAG_W-1:0]        rt [MEM_LATENCY];
  logic [TAG_W-1:0]        mem_tag;
  logic [EW-1:0]           head;
  logic                    ready_q, err_q, legal, acc, push, head_v, head_wr, issue, rd_issue, rsp_push, rsp_pop;
  always_comb begin
    legal     = ls__mc__cntl == 2'b01 || ls__mc__cntl == 2'b10;
    acc       = ls__mc__valid & ready_q;
    push      = acc & legal;
    head      = req_mem[req_rp];
    head_v    = req_cnt != '0;
    head_wr   = head[EW-1];
    credit    = {1'b0, out_cnt} + {1'b0, rsp_cnt};
    issue     = head_v & (head_wr | (credit < (RC+1)'(RSP_DEPTH)));
    rd_issue  = issue & ~head_wr;
    rsp_push  = rv[MEM_LATENCY-1];
    req_cnt_n = req_cnt + QC'(push) - QC'(issue);
    mc__ls__ready     = ready_q;
    mc__ls__err       = err_q;
    mc__ls__rsp_valid = rsp_cnt != '0;
    {mc__ls__rsp_tag, mc__ls__rsp_data} = mc__ls__rsp_valid ? rsp_mem[rsp_rp] : '0;
    rsp_pop   = mc__ls__rsp_valid & ls__mc__rsp_ready;
  end
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      ready_q         <= 1'b0;
      err_q           <= 1'b0;
      req_wp          <= '0;
      req_rp          <= '0;
      req_cnt         <= '0;
      rsp_wp          <= '0;
      rsp_rp          <= '0;
      rsp_cnt         <= '0;
      out_cnt         <= '0;
      rv              <= '0;
      mem_tag         <= '0;
      mc__mem__enable <= 1'b0;
      mc__mem__wr     <= 1'b0;
      mc__mem__addr   <= '0;
      mc__mem__wdata  <= '0;
    end else begin
      ready_q         <= req_cnt_n < QC'(REQ_DEPTH);
      req_cnt         <= req_cnt_n;
      err_q           <= err_q | (acc & ~legal);
      if (push) begin
        req_mem[req_wp] <= {ls__mc__cntl[1], ls__mc__tag, ls__mc__addr, ls__mc__data};
        req_wp          <= req_wp + 1'b1;
      end
      if (issue) begin
        req_rp         <= req_rp + 1'b1;
        mc__mem__addr  <= head[DATA_W +: ADDR_W];
        mc__mem__wdata <= head[DATA_W-1:0];
        mem_tag        <= head[DATA_W+ADDR_W +: TAG_W];
      end
      mc__mem__enable <= issue;
      mc__mem__wr     <= issue & head_wr;
      rv[0]           <= mc__mem__enable & ~mc__mem__wr;
      rt[0]           <= mem_tag;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        rv[i] <= rv[i-1];
        rt[i] <= rt[i-1];
      end
      out_cnt <= out_cnt + RC'(rd_issue) - RC'(rsp_push);
      rsp_cnt <= rsp_cnt + RC'(rsp_push) - RC'(rsp_pop);
      if (rsp_push) begin
        rsp_mem[rsp_wp] <= {rt[MEM_LATENCY-1], mem__mc__rdata};
        rsp_wp          <= rsp_wp == RW'(RSP_DEPTH - 1) ? '0 : rsp_wp + 1'b1;
      end
      if (rsp_pop) rsp_rp <= rsp_rp == RW'(RSP_DEPTH - 1) ? '0 : rsp_rp + 1'b1;
    end
  end
endmodule
